mem_stage: RTL and testbench

Memory-access stage of the 32-bit pipeline, between the EX-to-MEM pipeline register and the MEM-to-WB pipeline register. It owns the data memory and executes loads and stores with a fixed multi-cycle access latency. While an access is in flight it asserts `stall` to freeze the upstream stages and sends a bubble downstream. It forwards `WB_EN`, `MEM_R_EN`, `ALURes`, `memReadVal` and `dest` to the MEM-to-WB register.

---
 rtl/mem_pkg.sv | 12 +
 rtl/data_mem.sv | 37 +++
 rtl/mem_stage.sv | 113 +++++++++++
 tb/tb_mem_stage.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory-access stage.
//   mem_state_t     : access FSM states (IDLE, WAIT, DONE)
//   MEM_WORDS_DEF   : default data memory depth in 32-bit words
//   MEM_LATENCY_DEF : default stall cycles per memory access
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

    localparam int MEM_WORDS_DEF   = 64;
    localparam int MEM_LATENCY_DEF = 2;

endpackage

// File: rtl/data_mem.sv
// data_mem: WORDS x 32 data array with synchronous write and registered read.
//   clk, rst  : clock, synchronous active-high reset (clears array and read register)
//   we_i      : write wdata_i into addr_i on the clock edge
//   re_i      : capture the word at addr_i into the read register on the clock edge
//   addr_i    : word index
//   wdata_i   : write data
//   rdata_o   : read register; a same-edge read and write returns the pre-write word
module data_mem
    import mem_pkg::*;
#(
    parameter int WORDS = MEM_WORDS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            if (re_i) rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with a fixed multi-cycle data memory access.
//   clk, rst                               : clock, synchronous active-high reset
//   WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN     : control from the EX-to-MEM register
//   ALUResIn                               : ALU result, byte address for loads/stores
//   STValIn                                : store data
//   destIn                                 : destination register
//   WB_EN, MEM_R_EN, ALURes, memReadVal, dest : to the MEM-to-WB register
//   stall                                  : freezes PC, IF/ID/EX and the EX-to-MEM register
//   misalign                               : alignment fault pulse
// Build option MEM_ALIGN_CHECK_EN: squash misaligned memory ops and pulse misalign;
// when undefined the low address bits are ignored and misalign is tied 0.
module mem_stage
    import mem_pkg::*;
#(
    parameter int MEM_WORDS   = MEM_WORDS_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] STValIn,
    input  logic [4:0]  destIn,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic [31:0] ALURes,
    output logic [31:0] memReadVal,
    output logic [4:0]  dest,
    output logic        stall,
    output logic        misalign
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MEM_LATENCY) + 1;

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_op, mis_req, commit;
    logic          stall_c, wb_c, mis_c;

    assign mem_op = MEM_R_EN_IN | MEM_W_EN_IN;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_req = mem_op & (|ALUResIn[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    // WAIT ends once this cycle's decrement reaches zero; a latency of 1 loads
    // zero and the saturating counter still leaves WAIT after one cycle.
    assign commit = (state_q == WAIT) && (cnt_q <= CW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        wb_c    = WB_EN_IN;
        mis_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mis_req) begin
                    wb_c  = 1'b0;
                    mis_c = 1'b1;
                end else if (mem_op) begin
                    stall_c = 1'b1;
                    wb_c    = 1'b0;
                    state_d = WAIT;
                    cnt_d   = CW'(MEM_LATENCY - 1);
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                wb_c    = 1'b0;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                if (commit) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both enables set behaves as a store; the registered read still captures
    // the pre-write word on the same edge.
    data_mem #(.WORDS(MEM_WORDS)) u_data_mem (
        .clk    (clk),
        .rst    (rst),
        .we_i   (commit & MEM_W_EN_IN),
        .re_i   (commit & MEM_R_EN_IN),
        .addr_i (ALUResIn[AW+1:2]),
        .wdata_i(STValIn),
        .rdata_o(memReadVal)
    );

    assign stall    = stall_c & ~rst;
    assign WB_EN    = wb_c & ~rst;
    assign misalign = mis_c & ~rst;
    assign MEM_R_EN = MEM_R_EN_IN;
    assign ALURes   = ALUResIn;
    assign dest     = destIn;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: per-cycle scoreboard bench for mem_stage with MEM_LATENCY=2.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WB_EN_IN = 1'b0, MEM_R_EN_IN = 1'b0, MEM_W_EN_IN = 1'b0;
    logic [31:0] ALUResIn = '0, STValIn = '0;
    logic [4:0]  destIn = '0;
    logic        WB_EN, MEM_R_EN, stall, misalign;
    logic [31:0] ALURes, memReadVal;
    logic [4:0]  dest;

    typedef struct {
        logic        stall;
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] rv;
        logic [4:0]  d;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    mem_stage #(.MEM_WORDS(64), .MEM_LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .WB_EN_IN   (WB_EN_IN),
        .MEM_R_EN_IN(MEM_R_EN_IN),
        .MEM_W_EN_IN(MEM_W_EN_IN),
        .ALUResIn   (ALUResIn),
        .STValIn    (STValIn),
        .destIn     (destIn),
        .WB_EN      (WB_EN),
        .MEM_R_EN   (MEM_R_EN),
        .ALURes     (ALURes),
        .memReadVal (memReadVal),
        .dest       (dest),
        .stall      (stall),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus the outputs that cycle must show.
    task automatic step(input logic r, input logic wbi, input logic mri, input logic mwi,
                        input logic [31:0] a, input logic [31:0] sv, input logic [4:0] d,
                        input logic es, input logic ew, input logic [31:0] erv, input logic em);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; WB_EN_IN = wbi; MEM_R_EN_IN = mri; MEM_W_EN_IN = mwi;
        ALUResIn = a; STValIn = sv; destIn = d;
        e.stall = es; e.wb = ew; e.mr = mri; e.alu = a; e.rv = erv; e.d = d; e.mis = em;
        q.push_back(e);
    endtask

    // Aligned memory op: two stall cycles then DONE with the latched read data.
    task automatic memop(input logic mri, input logic mwi, input logic [31:0] a,
                         input logic [31:0] sv, input logic wbi, input logic [4:0] d,
                         input logic [31:0] rv0, input logic [31:0] rv1);
        step(1'b0, wbi, mri, mwi, a, sv, d, 1'b1, 1'b0, rv0, 1'b0);
        step(1'b0, wbi, mri, mwi, a, sv, d, 1'b1, 1'b0, rv0, 1'b0);
        step(1'b0, wbi, mri, mwi, a, sv, d, 1'b0, wbi,  rv1, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("stall",      32'(stall),    32'(e.stall));
                chk("WB_EN",      32'(WB_EN),    32'(e.wb));
                chk("MEM_R_EN",   32'(MEM_R_EN), 32'(e.mr));
                chk("ALURes",     ALURes,        e.alu);
                chk("memReadVal", memReadVal,    e.rv);
                chk("dest",       32'(dest),     32'(e.d));
                chk("misalign",   32'(misalign), 32'(e.mis));
            end
        end
    end

    initial begin
        logic [31:0] rvm;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h15, 32'h0, 5'd3, 1'b0, 1'b1, 32'h0, 1'b0);
        memop(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 32'h0);
        memop(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 5'd7, 32'h0, 32'hDEADBEEF);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 5'd9, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        memop(1'b0, 1'b1, 32'h4, 32'h3, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF);
        memop(1'b1, 1'b1, 32'h4, 32'h5, 1'b1, 5'd4, 32'hDEADBEEF, 32'h3);
        memop(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 5'd4, 32'h3, 32'h5);
`ifdef MEM_ALIGN_CHECK_EN
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h6, 32'h0,  5'd2, 1'b0, 1'b0, 32'h5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h6, 32'h77, 5'd0, 1'b0, 1'b0, 32'h5, 1'b1);
        memop(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 5'd4, 32'h5, 32'h5);
        rvm = 32'h5;
`else
        memop(1'b1, 1'b0, 32'h6, 32'h0,  1'b1, 5'd2, 32'h5, 32'h5);
        memop(1'b0, 1'b1, 32'h6, 32'h77, 1'b0, 5'd0, 32'h5, 32'h5);
        memop(1'b1, 1'b0, 32'h4, 32'h0,  1'b1, 5'd4, 32'h5, 32'h77);
        rvm = 32'h77;
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hAAAA5555, 5'd0, 1'b1, 1'b0, rvm, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'hAAAA5555, 5'd0, 1'b0, 1'b0, rvm, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 5'd1, 1'b0, 1'b1, 32'h0, 1'b0);
        memop(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 5'd6, 32'h0, 32'h0);
        memop(1'b1, 1'b0, 32'h8,  32'h0, 1'b1, 5'd6, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
